// File: rtl/seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv_unit
// Description : Iterative radix-2 multiply/divide unit producing a HI/LO pair
//               for MULTU/MULT/DIVU/DIV. One result bit per clock, followed
//               by a single sign-fix cycle that writes hi/lo and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0]    c_IDLE     = 2'd0;
  localparam logic [1:0]    c_CALC     = 2'd1;
  localparam logic [1:0]    c_FIX      = 2'd2;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz_pend;   // divide-by-zero detected at issue, CALC skipped
  logic             r_neg_lo;    // negate product (MUL) or quotient (DIV)
  logic             r_neg_hi;    // negate remainder (DIV only)
  logic [WIDTH-1:0] r_acc;       // MUL: upper partial product; DIV: partial remainder
  logic [WIDTH-1:0] r_q;         // MUL: multiplier shifting out; DIV: dividend in / quotient out
  logic [WIDTH-1:0] r_b;         // MUL: multiplicand; DIV: divisor
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Operand magnitudes and signs for the request presented on the inputs
  always_comb begin
    w_sign_a = op[0] & a[WIDTH-1];
    w_sign_b = op[0] & b[WIDTH-1];
    w_mag_a  = w_sign_a ? (~a + 1'b1) : a;
    w_mag_b  = w_sign_b ? (~b + 1'b1) : b;
  end

  // One shift-add / restoring shift-subtract step, plus the sign-fixed results
  always_comb begin
    w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_trial = {r_acc, r_q[WIDTH-1]};
    w_ge    = (w_trial >= {1'b0, r_b});
    // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice
    w_diff  = w_trial[WIDTH-1:0] - r_b;
    w_prod  = r_neg_lo ? (~{r_acc, r_q} + 1'b1) : {r_acc, r_q};
    w_quo   = r_neg_lo ? (~r_q + 1'b1) : r_q;
    w_rem   = r_neg_hi ? (~r_acc + 1'b1) : r_acc;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_dz_pend <= 1'b0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start && !cancel) begin
            r_is_div <= op[1];
            r_neg_lo <= w_sign_a ^ w_sign_b;
            r_neg_hi <= w_sign_a;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (op[1] && (b == '0)) begin
              // Raw dividend is parked in r_q so FIX can return it in hi
              r_dz_pend <= 1'b1;
              r_q       <= a;
              r_state   <= c_FIX;
            end else begin
              r_dz_pend <= 1'b0;
              r_state   <= c_CALC;
              if (op[1]) begin
                r_b <= w_mag_b;
                r_q <= w_mag_a;
              end else begin
                r_b <= w_mag_a;
                r_q <= w_mag_b;
              end
            end
          end
        end
        c_CALC: begin
          if (cancel) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            if (r_is_div) begin
              r_acc <= w_ge ? w_diff : w_trial[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_add[WIDTH:1];
              r_q   <= {w_add[0], r_q[WIDTH-1:1]};
            end
            if (r_cnt == c_CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= c_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_FIX: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
          if (!cancel) begin
            r_done <= 1'b1;
            if (r_dz_pend) begin
              r_hi  <= r_q;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else if (r_is_div) begin
              r_hi  <= w_rem;
              r_lo  <= w_quo;
              r_dbz <= 1'b0;
            end else begin
              r_hi  <= w_prod[2*WIDTH-1:WIDTH];
              r_lo  <= w_prod[WIDTH-1:0];
              r_dbz <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_muldiv_unit
// Description : Self-checking bench for seq_muldiv_unit. A 32-bit and an
//               8-bit instance are driven with directed and random requests
//               and compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op;
  logic        cancel;
  logic        start32, start8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op), .a(a32), .b(b32),
    .cancel(cancel), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32),
    .div_by_zero(dbz32)
  );

  seq_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op), .a(a8), .b(b8),
    .cancel(cancel), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
    .div_by_zero(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed/unsigned arithmetic on wide integers
  task automatic model(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    logic signed [127:0] sa, sb, p, q, r;
    logic [127:0] mask, u;
    mask = (128'd1 << w) - 128'd1;
    sa = $signed({96'd0, x});
    sb = $signed({96'd0, y});
    if (o[0] && x[w-1]) sa = sa - $signed(128'd1 << w);
    if (o[0] && y[w-1]) sb = sb - $signed(128'd1 << w);
    edz = 1'b0;
    if (!o[1]) begin
      p = sa * sb;
      u = p;
      ehi = 32'((u >> w) & mask);
      elo = 32'(u & mask);
    end else if (sb == 0) begin
      ehi = x;
      elo = 32'(mask);
      edz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      u = q;
      elo = 32'(u & mask);
      u = r;
      ehi = 32'(u & mask);
    end
  endtask

  function automatic logic [31:0] obs_hi(input bit s8);
    return s8 ? {24'd0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] obs_lo(input bit s8);
    return s8 ? {24'd0, lo8} : lo32;
  endfunction
  function automatic logic obs_done(input bit s8);
    return s8 ? done8 : done32;
  endfunction

  // Issue one request at the next falling edge and check latency and result.
  // With bump set, a second start is pulsed mid-operation and must be ignored.
  task automatic issue(input bit s8, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit bump, input string tag);
    int w, n;
    bit stable;
    logic [31:0] ehi, elo, phi, plo;
    logic edz;
    w = s8 ? 8 : 32;
    if (s8) begin x = x & 32'hFF; y = y & 32'hFF; end
    model(w, o, x, y, ehi, elo, edz);
    @(negedge clk);
    phi = obs_hi(s8);
    plo = obs_lo(s8);
    op = o;
    if (s8) begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    else    begin a32 = x;     b32 = y;     start32 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    n = 0; stable = 1'b1;
    while (!obs_done(s8) && n < 200) begin
      if (obs_hi(s8) !== phi || obs_lo(s8) !== plo) stable = 1'b0;
      if (bump && n == 4) begin
        op = ~o;
        if (s8) begin a8 = ~x[7:0]; start8 = 1'b1; end
        else    begin a32 = ~x;     start32 = 1'b1; end
      end
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      n++;
    end
    chk({tag, " latency"}, 64'(n), edz ? 64'd1 : 64'(w + 1));
    chk({tag, " hi"}, {32'd0, obs_hi(s8)}, {32'd0, ehi});
    chk({tag, " lo"}, {32'd0, obs_lo(s8)}, {32'd0, elo});
    chk({tag, " dbz"}, s8 ? 64'(dbz8) : 64'(dbz32), 64'(edz));
    chk({tag, " busy"}, s8 ? 64'(busy8) : 64'(busy32), 64'd0);
    if (!edz) chk({tag, " hold"}, 64'(stable), 64'd1);
  endtask

  initial begin
    int ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; cancel = 1'b0;
    op = 2'b00; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy32), 64'd0);
    chk("rst done", 64'(done32), 64'd0);
    chk("rst hi", 64'(hi32), 64'd0);
    chk("rst lo", 64'(lo32), 64'd0);
    chk("rst dbz", 64'(dbz32), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    issue(1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu max");
    chk("multu max hi const", 64'(hi32), 64'hFFFFFFFE);
    issue(1'b0, 2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, "mult neg");
    chk("mult neg lo const", 64'(lo32), 64'hFFFFFFEB);
    issue(1'b0, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, "div neg");
    issue(1'b0, 2'b10, 32'h40, 32'd0, 1'b0, "divu zero");
    issue(1'b0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div ovf");
    issue(1'b0, 2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0, "b2b mult");
    issue(1'b0, 2'b11, 32'd100, 32'hFFFFFFF9, 1'b1, "busy start");

    // Cancel a DIVU at E10, then issue a new request accepted at E11
    issue(1'b0, 2'b00, 32'd5, 32'd6, 1'b0, "pre cancel");
    @(negedge clk);
    op = 2'b10; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    ndone = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy", 64'(busy32), 64'd0);
    chk("cancel no done", 64'(ndone) + 64'(done32), 64'd0);
    chk("cancel hi kept", 64'(hi32), 64'd0);
    chk("cancel lo kept", 64'(lo32), 64'd30);
    issue(1'b0, 2'b10, 32'd1000, 32'd7, 1'b0, "after cancel");

    // cancel together with start in IDLE drops the start
    @(negedge clk);
    op = 2'b00; a32 = 32'd3; b32 = 32'd3; start32 = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; cancel = 1'b0;
    chk("cancel+start busy", 64'(busy32), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("cancel+start no done", 64'(ndone), 64'd0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      issue(1'b0, ro, ra, rb, 1'b0, "rand32");
    end

    // Reset in the middle of an 8-bit CALC clears every output
    issue(1'b1, 2'b00, 32'hC3, 32'h5A, 1'b0, "w8 pre rst");
    @(negedge clk);
    op = 2'b01; a8 = 8'h85; b8 = 8'h13; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("w8 rst busy", 64'(busy8), 64'd0);
    chk("w8 rst done", 64'(done8), 64'd0);
    chk("w8 rst hi", 64'(hi8), 64'd0);
    chk("w8 rst lo", 64'(lo8), 64'd0);
    chk("w8 rst dbz", 64'(dbz8), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    issue(1'b1, 2'b11, 32'h80, 32'hFF, 1'b0, "w8 div ovf");
    issue(1'b1, 2'b11, 32'h80, 32'h00, 1'b0, "w8 div zero");
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFF;
        2:       rb = 32'h80;
        default: rb = $urandom_range(0, 255);
      endcase
      issue(1'b1, ro, ra, rb, 1'b0, "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
